// File: rtl/shift_register_fifo_mc_pkg.sv
// Shared sizing helpers and the channel-index type for the multi-channel
// shift-register FIFO.
package shift_register_fifo_mc_pkg;

  // Widest channel index the decode helpers accept.
  localparam int MAX_CHW = 16;

  typedef logic [MAX_CHW-1:0] ch_idx_t;

  // Channel-select width; a single channel still gets a 1-bit index.
  function automatic int calc_chw(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

  // Occupancy counter width, able to hold the value DEPTH itself.
  function automatic int calc_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Out-of-range indices exist whenever NCH is not a power of two.
  function automatic logic ch_in_range(input ch_idx_t ch, input int nch);
    return int'(ch) < nch;
  endfunction

endpackage

// File: rtl/shift_register_channel.sv
// One shift-register FIFO channel: head is always mem[0], writes land at the
// tail slot, and a pop shifts the occupied entries down by one.
module shift_register_channel
  import shift_register_fifo_mc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int CW        = calc_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             do_push,
  input  logic             do_pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    cnt,
  output logic             empty,
  output logic             full,
  output logic             almost_full
);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] mem_nxt [DEPTH];
  logic [CW-1:0]    cnt_nxt;
  int               wr_idx;

  // do_push/do_pop arrive already qualified, so cnt never wraps here.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    for (int i = 0; i < DEPTH; i++) begin
      mem_nxt[i] = mem[i];
    end
    // NOTE: blocking assignments here because later statements must see the
    // shifted values; registered state below uses non-blocking only.
    wr_idx = do_pop ? int'(cnt) - 1 : int'(cnt);

    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if ((i + 1) < int'(cnt)) mem_nxt[i] = mem[i + 1];
      end
    end

    if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == wr_idx) mem_nxt[i] = data_in;
      end
    end

    cnt_nxt = cnt + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage is cleared on reset too, so that a formal run
      // starts from a fully known state and the head reads zero.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      cnt <= '0;
    end else begin
      mem <= mem_nxt;
      cnt <= cnt_nxt;
    end
  end

  assign head        = mem[0];
  assign empty       = (cnt == '0);
  assign full        = (cnt == CW'(DEPTH));
  assign almost_full = (cnt >= CW'(AF_THRESH));

endmodule

// File: rtl/shift_register_fifo_mc.sv
// NCH independent first-word-fall-through FIFOs behind one push port and one
// pop port, with sticky overflow/underflow flags for dropped requests.
module shift_register_fifo_mc
  import shift_register_fifo_mc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int NCH       = 2,
  parameter int AF_THRESH = DEPTH - 1,
  localparam int CHW      = calc_chw(NCH),
  localparam int CW       = calc_cw(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [CHW-1:0]    push_ch,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              pop,
  input  logic [CHW-1:0]    pop_ch,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_out_vld,
  output logic [NCH-1:0]    empty,
  output logic [NCH-1:0]    full,
  output logic [NCH-1:0]    almost_full,
  output logic [NCH*CW-1:0] count,
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow
);

  logic [WIDTH-1:0] head [NCH];
  logic [CW-1:0]    cnt  [NCH];
  logic [NCH-1:0]   push_ok;
  logic [NCH-1:0]   pop_ok;
  logic             push_in_range;
  logic             pop_in_range;
  logic             push_err;
  logic             pop_err;

  assign push_in_range = ch_in_range(ch_idx_t'(push_ch), NCH);
  assign pop_in_range  = ch_in_range(ch_idx_t'(pop_ch), NCH);

  // A full channel still accepts a push when it is popped in the same cycle;
  // an empty channel never accepts a pop, even alongside a push (no bypass).
  always_comb begin
    pop_ok  = '0;
    push_ok = '0;
    for (int c = 0; c < NCH; c++) begin
      pop_ok[c]  = pop && pop_in_range && (pop_ch == CHW'(c)) && !empty[c];
      push_ok[c] = push && push_in_range && (push_ch == CHW'(c)) &&
                   (!full[c] || pop_ok[c]);
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    shift_register_channel #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH),
      .CW        (CW)
    ) u_channel (
      .clk         (clk),
      .rst         (rst),
      .do_push     (push_ok[c]),
      .do_pop      (pop_ok[c]),
      .data_in     (data_in),
      .head        (head[c]),
      .cnt         (cnt[c]),
      .empty       (empty[c]),
      .full        (full[c]),
      .almost_full (almost_full[c])
    );

    assign count[c*CW +: CW] = cnt[c];
  end

  // Output mux; an out-of-range pop_ch falls through to the zero default.
  always_comb begin
    data_out     = '0;
    data_out_vld = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (pop_ch == CHW'(c)) begin
        data_out     = head[c];
        data_out_vld = !empty[c];
      end
    end
  end

  assign push_err = push && !(|push_ok);
  assign pop_err  = pop && !(|pop_ok);

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= push_err | (overflow & ~err_clr);
      underflow <= pop_err | (underflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_shift_register_fifo_mc.sv
// Directed bench for shift_register_fifo_mc: a 2-channel instance for the
// main FIFO behaviour and a 3-channel instance for out-of-range indices.
module tb_shift_register_fifo_mc;

  logic clk;

  // 2-channel instance (CHW=1, CW=3)
  logic       d2_rst, d2_push, d2_pop, d2_err_clr;
  logic [0:0] d2_push_ch, d2_pop_ch;
  logic [7:0] d2_data_in, d2_data_out;
  logic       d2_vld, d2_ovf, d2_udf;
  logic [1:0] d2_empty, d2_full, d2_af;
  logic [5:0] d2_count;

  // 3-channel instance (CHW=2, CW=3)
  logic       d3_rst, d3_push, d3_pop, d3_err_clr;
  logic [1:0] d3_push_ch, d3_pop_ch;
  logic [7:0] d3_data_in, d3_data_out;
  logic       d3_vld, d3_ovf, d3_udf;
  logic [2:0] d3_empty, d3_full, d3_af;
  logic [8:0] d3_count;

  int n_cmp = 0;
  int n_bad = 0;

  shift_register_fifo_mc #(.WIDTH(8), .DEPTH(4), .NCH(2)) u_dut2 (
    .clk(clk), .rst(d2_rst), .push(d2_push), .push_ch(d2_push_ch),
    .data_in(d2_data_in), .pop(d2_pop), .pop_ch(d2_pop_ch),
    .data_out(d2_data_out), .data_out_vld(d2_vld), .empty(d2_empty),
    .full(d2_full), .almost_full(d2_af), .count(d2_count),
    .err_clr(d2_err_clr), .overflow(d2_ovf), .underflow(d2_udf)
  );

  shift_register_fifo_mc #(.WIDTH(8), .DEPTH(4), .NCH(3)) u_dut3 (
    .clk(clk), .rst(d3_rst), .push(d3_push), .push_ch(d3_push_ch),
    .data_in(d3_data_in), .pop(d3_pop), .pop_ch(d3_pop_ch),
    .data_out(d3_data_out), .data_out_vld(d3_vld), .empty(d3_empty),
    .full(d3_full), .almost_full(d3_af), .count(d3_count),
    .err_clr(d3_err_clr), .overflow(d3_ovf), .underflow(d3_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op2(input logic ps, input logic [0:0] pc, input logic [7:0] d,
                     input logic pp, input logic [0:0] ppc, input logic clr);
    d2_push = ps; d2_push_ch = pc; d2_data_in = d;
    d2_pop = pp; d2_pop_ch = ppc; d2_err_clr = clr;
    cyc();
    d2_push = 1'b0; d2_pop = 1'b0; d2_err_clr = 1'b0;
    #1;
  endtask

  task automatic op3(input logic ps, input logic [1:0] pc, input logic [7:0] d,
                     input logic pp, input logic [1:0] ppc, input logic clr);
    d3_push = ps; d3_push_ch = pc; d3_data_in = d;
    d3_pop = pp; d3_pop_ch = ppc; d3_err_clr = clr;
    cyc();
    d3_push = 1'b0; d3_pop = 1'b0; d3_err_clr = 1'b0;
    #1;
  endtask

  initial begin
    d2_rst = 1'b1; d2_push = 1'b0; d2_pop = 1'b0; d2_err_clr = 1'b0;
    d2_push_ch = '0; d2_pop_ch = '0; d2_data_in = '0;
    d3_rst = 1'b1; d3_push = 1'b0; d3_pop = 1'b0; d3_err_clr = 1'b0;
    d3_push_ch = '0; d3_pop_ch = '0; d3_data_in = '0;
    cyc();
    cyc();
    d2_rst = 1'b0;
    d3_rst = 1'b0;
    #1;

    // Reset state
    chk("rst_empty", 32'(d2_empty), 32'h3);
    chk("rst_full", 32'(d2_full), 32'h0);
    chk("rst_af", 32'(d2_af), 32'h0);
    chk("rst_count", 32'(d2_count), 32'h0);
    chk("rst_ovf", 32'(d2_ovf), 32'h0);
    chk("rst_udf", 32'(d2_udf), 32'h0);
    chk("rst_vld", 32'(d2_vld), 32'h0);
    chk("rst_dout", 32'(d2_data_out), 32'h0);

    // Fill ch0; first push visible the next cycle
    op2(1, 0, 8'h11, 0, 0, 0);
    chk("lat_dout", 32'(d2_data_out), 32'h11);
    chk("lat_vld", 32'(d2_vld), 32'h1);
    op2(1, 0, 8'h22, 0, 0, 0);
    chk("af_cnt2", 32'(d2_af), 32'h0);
    op2(1, 0, 8'h33, 0, 0, 0);
    chk("af_cnt3", 32'(d2_af), 32'h1);
    chk("full_cnt3", 32'(d2_full), 32'h0);
    op2(1, 0, 8'h44, 0, 0, 0);
    chk("full_cnt4", 32'(d2_full), 32'h1);
    chk("count_4", 32'(d2_count), 32'h4);
    chk("empty_ch1", 32'(d2_empty), 32'h2);
    chk("head_11", 32'(d2_data_out), 32'h11);

    // Full ch0: push with same-cycle pop is accepted
    op2(1, 0, 8'h55, 1, 0, 0);
    chk("pp_count", 32'(d2_count), 32'h4);
    chk("pp_ovf", 32'(d2_ovf), 32'h0);
    chk("pp_head", 32'(d2_data_out), 32'h22);

    // Full ch0: push alone is dropped
    op2(1, 0, 8'h66, 0, 0, 0);
    chk("drop_ovf", 32'(d2_ovf), 32'h1);
    chk("drop_count", 32'(d2_count), 32'h4);

    // Drain ch0 in order; 0x55 comes out last
    chk("drain_0", 32'(d2_data_out), 32'h22);
    op2(0, 0, 8'h00, 1, 0, 0);
    chk("drain_1", 32'(d2_data_out), 32'h33);
    op2(0, 0, 8'h00, 1, 0, 0);
    chk("drain_2", 32'(d2_data_out), 32'h44);
    op2(0, 0, 8'h00, 1, 0, 0);
    chk("drain_3", 32'(d2_data_out), 32'h55);
    op2(0, 0, 8'h00, 1, 0, 0);
    chk("drain_empty", 32'(d2_empty), 32'h3);
    chk("drain_vld", 32'(d2_vld), 32'h0);
    chk("drain_udf", 32'(d2_udf), 32'h0);

    // Push ch1 and pop ch0 in the same cycle
    op2(1, 0, 8'h01, 0, 0, 0);
    op2(1, 0, 8'h02, 0, 0, 0);
    op2(1, 1, 8'hA0, 1, 0, 0);
    chk("xch_count", 32'(d2_count), 32'h09);
    chk("xch_head0", 32'(d2_data_out), 32'h02);
    d2_pop_ch = 1'b1;
    #1;
    chk("xch_head1", 32'(d2_data_out), 32'hA0);

    // Empty ch1, then pop it while pushing 0x77: pop ignored, push taken
    op2(0, 0, 8'h00, 1, 1, 0);
    chk("ch1_popped", 32'(d2_count), 32'h01);
    op2(1, 1, 8'h77, 1, 1, 0);
    chk("nobyp_udf", 32'(d2_udf), 32'h1);
    chk("nobyp_count", 32'(d2_count), 32'h09);
    chk("nobyp_head", 32'(d2_data_out), 32'h77);
    chk("nobyp_vld", 32'(d2_vld), 32'h1);

    // err_clr alone clears both flags
    op2(0, 0, 8'h00, 0, 1, 1);
    chk("clr_ovf", 32'(d2_ovf), 32'h0);
    chk("clr_udf", 32'(d2_udf), 32'h0);

    // err_clr with a new bad pop: the error wins
    op2(0, 0, 8'h00, 1, 0, 0);
    chk("pop_ch0_last", 32'(d2_count), 32'h08);
    op2(0, 0, 8'h00, 1, 0, 1);
    chk("clrwin_udf", 32'(d2_udf), 32'h1);
    chk("clrwin_ovf", 32'(d2_ovf), 32'h0);

    // NCH=3: channel index 3 is out of range
    op3(1, 2'd3, 8'h99, 0, 2'd0, 0);
    chk("oor_ovf", 32'(d3_ovf), 32'h1);
    chk("oor_count", 32'(d3_count), 32'h0);
    chk("oor_empty", 32'(d3_empty), 32'h7);
    op3(0, 2'd0, 8'h00, 1, 2'd3, 0);
    chk("oor_udf", 32'(d3_udf), 32'h1);
    chk("oor_vld", 32'(d3_vld), 32'h0);

    // Reset mid-stream discards ch0 contents, even with a push pending
    op3(1, 2'd0, 8'hA1, 0, 2'd0, 0);
    op3(1, 2'd0, 8'hA2, 0, 2'd0, 0);
    op3(1, 2'd0, 8'hA3, 0, 2'd0, 0);
    chk("pre_rst_count", 32'(d3_count), 32'h3);
    chk("pre_rst_af", 32'(d3_af), 32'h1);
    chk("pre_rst_head", 32'(d3_data_out), 32'hA1);
    d3_rst = 1'b1;
    op3(1, 2'd0, 8'hB0, 0, 2'd0, 0);
    d3_rst = 1'b0;
    chk("mid_rst_empty", 32'(d3_empty), 32'h7);
    chk("mid_rst_count", 32'(d3_count), 32'h0);
    chk("mid_rst_dout", 32'(d3_data_out), 32'h0);
    chk("mid_rst_vld", 32'(d3_vld), 32'h0);
    chk("mid_rst_ovf", 32'(d3_ovf), 32'h0);
    chk("mid_rst_udf", 32'(d3_udf), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_register_fifo_mc.md
Name: shift_register_fifo_mc

Overview:
Multi-channel, parametrised successor to the single-channel shift-register FIFO. It provides NCH independent FIFOs of DEPTH x WIDTH, with one push port and one pop port, each steered by a channel index. The outputs are first-word-fall-through. Misuse is flagged through sticky overflow/underflow flags, so full/empty do not have to be constrained externally. The block sits under the formal top with one scoreboard per channel; data_out/data_out_vld feed the scoreboard directly.

Parameters:
WIDTH, 8, data width in bits
DEPTH, 4, entries per channel (>=2)
NCH, 2, number of channels (>=1; need not be a power of 2)
AF_THRESH, DEPTH-1, per-channel almost_full asserts when count >= AF_THRESH (1..DEPTH)

Ports:
clk  in  1  clock; all state on posedge
rst  in  1  synchronous, active-high reset
push  in  1  write request
push_ch  in  CHW  target channel of push; CHW = max(1,clog2(NCH))
data_in  in  WIDTH  write data
pop  in  1  read request
pop_ch  in  CHW  channel popped and shown on data_out
data_out  out  WIDTH  head entry of channel pop_ch (combinational)
data_out_vld  out  1  = !empty[pop_ch] and pop_ch < NCH
empty  out  NCH  per-channel empty
full  out  NCH  per-channel full
almost_full  out  NCH  per-channel count >= AF_THRESH
count  out  NCH*CW  per-channel occupancy; CW = clog2(DEPTH+1); channel c at bits [c*CW +: CW]
err_clr  in  1  clears the sticky error flags
overflow  out  1  sticky: a push was dropped
underflow  out  1  sticky: a pop was ignored

Behaviour:
- Storage per channel c: shift array mem[c][0..DEPTH-1] and counter cnt[c]; head is always mem[c][0].
- Reset (rst=1 at posedge):
  - all cnt=0 and all mem=0, so formal starts deterministic;
  - overflow=underflow=0.
  - Outputs after reset: empty=all 1, full=0, almost_full=0 (AF_THRESH>=1), count=0, data_out=0, data_out_vld=0.
  - rst dominates push/pop/err_clr; a reset mid-stream discards all contents.
- Valid push: push=1, push_ch<NCH, and channel not full, or full with a same-channel valid pop this cycle.
- Valid pop: pop=1, pop_ch<NCH, channel not empty. A push to an empty channel in the same cycle does not make the pop valid (no bypass).
- Per channel, next state:
  - push only: mem[cnt]<=data_in; cnt+1.
  - pop only: mem[i]<=mem[i+1] for i<cnt-1; cnt-1; vacated slot holds its old value.
  - push+pop same channel: shift down, and mem[cnt-1]<=data_in; cnt unchanged. This also covers the full case.
  - push and pop on different channels: fully independent; both take effect the same cycle.
- Latency: data pushed into an empty channel is visible on data_out (with pop_ch selecting it) the cycle after the push.
- Invalid push: data is dropped, no state change, overflow<=1.
- Invalid pop: no state change, underflow<=1. data_out is don't-care when data_out_vld=0.
- Out-of-range channel index (NCH not a power of 2) counts as invalid (overflow/underflow respectively).
- err_clr=1 clears both flags next cycle. An error event in the same cycle wins (flag stays 1).
- Invariants:
  - empty[c] == (cnt[c]==0) and full[c] == (cnt[c]==DEPTH);
  - never empty and full together;
  - cnt[c] <= DEPTH.
- With NCH=1 and no misuse, behaviour is cycle-identical to the existing single-channel FIFO.

Decomposition:
- Package shift_register_fifo_mc_pkg holds:
  - functions calc_chw(NCH) and calc_cw(DEPTH);
  - a typedef for the channel index.
- One natural sub-module, shift_register_channel (WIDTH, DEPTH, AF_THRESH): takes do_push/do_pop qualified by the top, and outputs head, cnt, empty, full, almost_full.
- The top generates NCH instances plus the index decode, output mux and error flags.

Test Plan:
- Reset then idle, NCH=2, DEPTH=4 -> empty=2'b11, full=0, count=0, overflow=underflow=0, data_out_vld=0.
- Push 0x11,0x22,0x33,0x44 to ch0, then pop_ch=0 with 4 pops -> data_out 0x11,0x22,0x33,0x44 in order; full[0]=1 after the 4th push; almost_full[0]=1 from count 3; ch1 stays empty.
- ch0 full, push 0x55 with a same-cycle pop on ch0 -> pops 0x11, count stays 4, 0x55 ends last, overflow=0. Push to full ch0 without pop -> dropped, overflow=1, count[0]=4.
- Same cycle: push 0xA0 to ch1 and pop ch0 (holding 2 entries) -> count[1]=1, count[0]=1, and ch0 head advances.
- Pop empty ch1 while pushing 0x77 to ch1 -> underflow=1, count[1]=1, head 0x77. Assert err_clr alone -> flags 0 next cycle. Assert err_clr together with a new bad pop -> underflow stays 1.
- NCH=3: push_ch=3 -> overflow=1, no channel changes. Assert rst while ch0 holds 3 entries -> all empty, data_out=0 next cycle.
